// File: rtl/axi_llc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_pkg
// Brief    : Shared LLC types for the eviction W path: config, unit tags and
//            descriptor / data-way / AXI W payload structs.
// Revision : 1.0
// ============================================================================
package axi_llc_pkg;

    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned DATA_WIDTH    = 64;
    localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8;
    localparam int unsigned WAY_IND_WIDTH = 4;
    localparam int unsigned IDX_WIDTH     = 8;
    localparam int unsigned BLK_OFF_WIDTH = 2;

    typedef struct packed {
        logic [31:0] BlockSize;
        logic [31:0] BlockOffsetLength;
        logic [31:0] ByteOffsetLength;
        logic [31:0] IndexLength;
    } llc_cfg_t;

    localparam llc_cfg_t DEFAULT_CFG = '{
        BlockSize:         32'd4,
        BlockOffsetLength: 32'd2,
        ByteOffsetLength:  32'd3,
        IndexLength:       32'd8
    };

    typedef struct packed {
        logic [31:0] AddrWidth;
        logic [31:0] DataWidth;
    } axi_cfg_t;

    localparam axi_cfg_t DEFAULT_AXI_CFG = '{AddrWidth: 32'd32, DataWidth: 32'd64};

    typedef enum logic [1:0] {
        EvictUnit = 2'd0,
        RefilUnit = 2'd1,
        RwUnit    = 2'd2
    } cache_unit_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    a_x_addr;
        logic [WAY_IND_WIDTH-1:0] way_ind;
        logic                     evict;
    } desc_t;

    typedef struct packed {
        cache_unit_e              cache_unit;
        logic [WAY_IND_WIDTH-1:0] way_ind;
        logic [IDX_WIDTH-1:0]     line_addr;
        logic [BLK_OFF_WIDTH-1:0] blk_offset;
        logic                     we;
        logic [STRB_WIDTH-1:0]    be;
        logic [DATA_WIDTH-1:0]    data;
    } way_inp_t;

    typedef struct packed {
        cache_unit_e           cache_unit;
        logic [DATA_WIDTH-1:0] data;
    } way_oup_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
        logic [0:0]            user;
    } w_chan_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        SEND  = 2'd3
    } evict_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// Module   : fifo_v3
// Brief    : Synchronous FIFO, optional fall-through, active-low async reset.
// Revision : 1.0
// ============================================================================
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    dtype                  mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_q, wr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    logic                  w_push, w_pop, w_bypass;

    assign full_o   = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o  = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign data_o   = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_q];
    assign w_push   = push_i && !full_o;
    assign w_pop    = pop_i && !empty_o;
    // Fall-through with an empty buffer hands the word straight across.
    assign w_bypass = FALL_THROUGH && (cnt_q == '0) && w_push && w_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (!w_bypass) begin
            if (w_push) begin
                wr_q <= (wr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : wr_q + 1'b1;
            end
            if (w_pop) begin
                rd_q <= (rd_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : rd_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !w_bypass && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_llc_evict_w_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_evict_w_master
// Brief    : Reads a victim line from the data ways and emits it as one AXI
//            W burst, then forwards the descriptor. Optional eviction counter
//            enabled by defining AXI_LLC_EVICT_CNT_EN.
// Revision : 1.0
// ============================================================================
module axi_llc_evict_w_master
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t    Cfg       = DEFAULT_CFG,
    parameter axi_cfg_t    AxiCfg    = DEFAULT_AXI_CFG,
    parameter type         desc_t    = axi_llc_pkg::desc_t,
    parameter type         way_inp_t = axi_llc_pkg::way_inp_t,
    parameter type         way_oup_t = axi_llc_pkg::way_oup_t,
    parameter type         w_chan_t  = axi_llc_pkg::w_chan_t,
    parameter int unsigned FifoDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  desc_t       desc_i,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    output desc_t       desc_o,
    output logic        desc_valid_o,
    input  logic        desc_ready_i,
    output way_inp_t    way_inp_o,
    output logic        way_inp_valid_o,
    input  logic        way_inp_ready_i,
    input  way_oup_t    way_out_i,
    input  logic        way_out_valid_i,
    output logic        way_out_ready_o,
    output w_chan_t     w_chan_mst_o,
    output logic        w_chan_valid_o,
    input  logic        w_chan_ready_i,
    output logic [31:0] evict_cnt_o
);

    localparam int unsigned CNT_W = cnt_width(Cfg.BlockSize);
    localparam int unsigned OUT_W = $clog2(FifoDepth + 1);
    localparam int unsigned SHAMT = Cfg.ByteOffsetLength + Cfg.BlockOffsetLength;

    evict_state_e            state_q, state_d;
    desc_t                   desc_q, desc_d;
    logic [CNT_W-1:0]        req_q, req_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic [OUT_W-1:0]        outst_q, outst_d;
    logic                    w_req_hs, w_w_hs, w_last, w_accept;
    logic                    w_fifo_full, w_fifo_empty, w_push;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [31:0]             w_line;
    logic                    w_unused;

    assign w_w_hs  = w_chan_valid_o && w_chan_ready_i;
    assign w_last  = (beat_q == CNT_W'(Cfg.BlockSize - 1));
    assign w_line  = (32'(desc_q.a_x_addr) >> SHAMT) & ((32'd1 << Cfg.IndexLength) - 32'd1);
    assign desc_o  = desc_q;
    assign w_unused = ^{way_out_i.cache_unit, AxiCfg};

    // Responses only belong to an eviction in flight; anything arriving after
    // a reset abandoned a burst must not turn into a W beat.
    assign way_out_ready_o = !w_fifo_full && ((state_q == READ) || (state_q == DRAIN));
    assign w_push          = way_out_valid_i && way_out_ready_o;
    assign w_chan_valid_o  = !w_fifo_empty;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (FifoDepth)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (!rst_i),
        .flush_i (1'b0),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .data_i  (way_out_i.data),
        .push_i  (w_push),
        .data_o  (w_head),
        .pop_i   (w_w_hs)
    );

    always_comb begin
        way_inp_o            = '0;
        way_inp_o.we         = 1'b0;
        way_inp_o.cache_unit = EvictUnit;
        way_inp_o.way_ind    = desc_q.way_ind;
        way_inp_o.line_addr  = IDX_WIDTH'(w_line);
        way_inp_o.blk_offset = BLK_OFF_WIDTH'(req_q);

        w_chan_mst_o      = '0;
        w_chan_mst_o.data = w_head;
        w_chan_mst_o.strb = '1;
        w_chan_mst_o.last = w_last;
        w_chan_mst_o.user = '0;
    end

    always_comb begin
        state_d         = state_q;
        desc_d          = desc_q;
        req_d           = req_q;
        beat_d          = beat_q;
        outst_d         = outst_q;
        desc_ready_o    = 1'b0;
        desc_valid_o    = 1'b0;
        way_inp_valid_o = 1'b0;
        w_req_hs        = 1'b0;
        w_accept        = 1'b0;

        case (state_q)
            IDLE: w_accept = 1'b1;
            READ: begin
                // A W pop in the same cycle frees a slot, keeping 1 beat/cycle.
                way_inp_valid_o = (outst_q < OUT_W'(FifoDepth)) || w_w_hs;
                w_req_hs        = way_inp_valid_o && way_inp_ready_i;
                if (w_req_hs) begin
                    req_d = req_q + 1'b1;
                    if (req_q == CNT_W'(Cfg.BlockSize - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_w_hs && w_last) begin
                    desc_valid_o = 1'b1;
                    if (desc_ready_i) begin
                        w_accept = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                desc_valid_o = 1'b1;
                if (desc_ready_i) begin
                    w_accept = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_w_hs) begin
            beat_d = w_last ? '0 : beat_q + 1'b1;
        end

        case ({w_req_hs, w_w_hs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        if (w_accept) begin
            desc_ready_o = 1'b1;
            state_d      = IDLE;
            if (desc_valid_i) begin
                desc_d  = desc_i;
                state_d = desc_i.evict ? READ : SEND;
                req_d   = '0;
                beat_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            desc_q  <= '0;
            req_q   <= '0;
            beat_q  <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            req_q   <= req_d;
            beat_q  <= beat_d;
            outst_q <= outst_d;
        end
    end

`ifdef AXI_LLC_EVICT_CNT_EN
    logic [31:0] evict_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evict_cnt_q <= '0;
        end else if (desc_valid_o && desc_ready_i && desc_q.evict) begin
            evict_cnt_q <= evict_cnt_q + 32'd1;
        end
    end

    assign evict_cnt_o = evict_cnt_q;
`else
    assign evict_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_evict_w_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_llc_evict_w_master
// Brief    : Directed scoreboard bench for the eviction W master.
// Revision : 1.0
// ============================================================================
module tb_axi_llc_evict_w_master;
    import axi_llc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    desc_t       desc_i, desc_o;
    logic        desc_valid_i, desc_ready_o, desc_valid_o, desc_ready_i;
    way_inp_t    way_inp_o;
    logic        way_inp_valid_o, way_inp_ready_i;
    way_oup_t    way_out_i;
    logic        way_out_valid_i, way_out_ready_o;
    w_chan_t     w_chan_mst_o;
    logic        w_chan_valid_o, w_chan_ready_i;
    logic [31:0] evict_cnt_o;

    always #5 clk = ~clk;

    axi_llc_evict_w_master #(.FifoDepth(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .desc_i(desc_i), .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_o(desc_o), .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
        .way_inp_o(way_inp_o), .way_inp_valid_o(way_inp_valid_o), .way_inp_ready_i(way_inp_ready_i),
        .way_out_i(way_out_i), .way_out_valid_i(way_out_valid_i), .way_out_ready_o(way_out_ready_o),
        .w_chan_mst_o(w_chan_mst_o), .w_chan_valid_o(w_chan_valid_o), .w_chan_ready_i(w_chan_ready_i),
        .evict_cnt_o(evict_cnt_o)
    );

    typedef struct { logic [63:0] data; logic last; } wexp_t;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          n_wbeats = 0;
    int          inflight = 0;
    wexp_t       w_q[$];
    desc_t       d_q[$];
    logic [63:0] pend[$];
    logic [7:0]  exp_line;
    logic [3:0]  exp_way;
    logic [1:0]  exp_off;
    logic        req_fire, rsp_fire, stalled;
    logic [63:0] req_data, held;

    function automatic logic [63:0] mk_data(input logic [3:0] way, input logic [7:0] line,
                                            input logic [1:0] off);
        return {8'hD0, 20'h0, way, 16'h0, line, 6'h0, off};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Data-way model: one-cycle read latency, responses held until accepted.
    always @(negedge clk) begin
        req_fire = way_inp_valid_o && way_inp_ready_i && !rst;
        rsp_fire = way_out_valid_i && way_out_ready_o && !rst;
        req_data = mk_data(way_inp_o.way_ind, way_inp_o.line_addr, way_inp_o.blk_offset);
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            pend.delete();
        end else begin
            if (rsp_fire && pend.size() > 0) void'(pend.pop_front());
            if (req_fire) pend.push_back(req_data);
        end
        way_out_valid_i      = (pend.size() > 0);
        way_out_i.cache_unit = EvictUnit;
        way_out_i.data       = (pend.size() > 0) ? pend[0] : 64'h0;
    end

    // Monitor: way requests, W beats and outgoing descriptors.
    always @(negedge clk) begin
        wexp_t e;
        desc_t d;
        if (rst) begin
            stalled  = 1'b0;
            inflight = 0;
            exp_off  = 2'd0;
        end else begin
            if (stalled) begin
                chk("w_hold_valid", 64'(w_chan_valid_o), 64'd1);
                chk("w_hold_data", w_chan_mst_o.data, held);
            end
            if (way_inp_valid_o && way_inp_ready_i) begin
                chk("req_blk_offset", 64'(way_inp_o.blk_offset), 64'(exp_off));
                chk("req_line_addr", 64'(way_inp_o.line_addr), 64'(exp_line));
                chk("req_way_we", {way_inp_o.way_ind, way_inp_o.we}, {exp_way, 1'b0});
                chk("req_unit", 64'(way_inp_o.cache_unit), 64'(EvictUnit));
                exp_off++;
                inflight++;
            end
            if (w_chan_valid_o && w_chan_ready_i) begin
                if (w_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL w_unexpected: got beat %0h expected none", w_chan_mst_o.data);
                end else begin
                    e = w_q.pop_front();
                    chk("w_data", w_chan_mst_o.data, e.data);
                    chk("w_last", 64'(w_chan_mst_o.last), 64'(e.last));
                    chk("w_strb_user", {w_chan_mst_o.strb, w_chan_mst_o.user}, {8'hFF, 1'b0});
                end
                inflight--;
                n_wbeats++;
            end
            chk("outstanding_le_2", 64'(inflight <= 2), 64'd1);
            stalled = w_chan_valid_o && !w_chan_ready_i;
            held    = w_chan_mst_o.data;
            if (desc_valid_o && desc_ready_i) begin
                if (d_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL desc_unexpected: got %0h expected none", desc_o);
                end else begin
                    d = d_q.pop_front();
                    chk("desc_out", 64'(desc_o), 64'(d));
                end
            end
        end
    end

    task automatic send_desc(input logic [31:0] addr, input logic [3:0] way, input logic ev,
                             input logic [7:0] line);
        desc_t d;
        bit    ok = 0;
        d = '{a_x_addr: addr, way_ind: way, evict: ev};
        if (ev) begin
            exp_line = line;
            exp_way  = way;
            for (int k = 0; k < 4; k++) w_q.push_back('{mk_data(way, line, 2'(k)), k == 3});
        end
        d_q.push_back(d);
        @(posedge clk); #1;
        desc_i       = d;
        desc_valid_i = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (desc_ready_o) begin ok = 1; break; end
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL desc_accept_timeout: got ready 0 expected 1");
        end
        @(posedge clk); #1;
        desc_valid_i = 1'b0;
        if (!ev) begin
            @(negedge clk);
            chk("nonevict_valid_next", 64'(desc_valid_o), 64'd1);
        end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            if (w_q.size() == 0 && d_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL drain_timeout: got %0d beats %0d descs pending expected 0", w_q.size(), d_q.size());
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_beats(input int target);
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (n_wbeats >= target) begin ok = 1; break; end
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", n_wbeats, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        desc_i = '0; desc_valid_i = 1'b0; desc_ready_i = 1'b1;
        way_inp_ready_i = 1'b1; w_chan_ready_i = 1'b1;
        way_out_valid_i = 1'b0; way_out_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", {desc_valid_o, w_chan_valid_o, way_inp_valid_o}, 3'b000);
        chk("rst_desc_o", 64'(desc_o), 64'd0);
        chk("rst_evict_cnt", 64'(evict_cnt_o), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(desc_ready_o), 64'd1);

        // Reset after beat 2 of 4 abandons the burst.
        send_desc(32'h0000_0460, 4'h1, 1'b1, 8'h23);
        wait_beats(2);
        #2;
        rst = 1'b1;
        w_q.delete(); d_q.delete(); pend.delete();
        way_out_valid_i = 1'b0;
        #1;
        chk("midrst_outputs_zero", {desc_valid_o, w_chan_valid_o, way_inp_valid_o}, 3'b000);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("postrst_no_w", 64'(w_chan_valid_o), 64'd0);
        end

        // Full-rate eviction; offsets must restart at 0 after the reset.
        send_desc(32'h0000_1A40, 4'h3, 1'b1, 8'hD2);
        wait_done();

        send_desc(32'h0000_0FE0, 4'h2, 1'b0, 8'h00);
        wait_done();

        // W back-pressure for 10 cycles mid-burst.
        send_desc(32'h0001_FFE0, 4'h5, 1'b1, 8'hFF);
        wait_beats(n_wbeats + 1);
        #1;
        w_chan_ready_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        w_chan_ready_i = 1'b1;
        wait_done();

        // Descriptor back-pressure, then same-cycle acceptance on release.
        desc_ready_i = 1'b0;
        send_desc(32'h0000_0020, 4'hA, 1'b1, 8'h01);
        begin
            bit ok = 0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (desc_valid_o) begin ok = 1; break; end
            end
            if (!ok) begin
                n_vec++; n_fail++;
                $display("FAIL send_timeout: got desc_valid 0 expected 1");
            end
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("send_hold_valid", 64'(desc_valid_o), 64'd1);
            chk("send_hold_desc", 64'(desc_o), 64'({32'h0000_0020, 4'hA, 1'b1}));
        end
        d_q.push_back('{a_x_addr: 32'hCAFE_0000, way_ind: 4'h7, evict: 1'b0});
        @(posedge clk); #1;
        desc_ready_i = 1'b1;
        desc_valid_i = 1'b1;
        desc_i       = '{a_x_addr: 32'hCAFE_0000, way_ind: 4'h7, evict: 1'b0};
        @(negedge clk);
        chk("release_same_cycle_accept", 64'(desc_ready_o), 64'd1);
        @(posedge clk); #1;
        desc_valid_i = 1'b0;
        wait_done();

`ifdef AXI_LLC_EVICT_CNT_EN
        chk("evict_cnt", 64'(evict_cnt_o), 64'd3);
`else
        chk("evict_cnt", 64'(evict_cnt_o), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
